// File: rtl/nes_joypad_poller.sv
// Autonomous NES pad poller: latch, eight shift clocks and a presence read each frame.
// Build option: define JOY_DEBOUNCE_EN to publish buttons only after two identical frames.
module nes_joypad_poller #(
  parameter int C_clk_hz        = 21428571,
  parameter int C_poll_hz       = 1000,
  parameter int C_strobe_cycles = 256,
  parameter int C_half_cycles   = 128
) (
  input  logic       clock,
  input  logic       R_reset,
  input  logic       joy_data,
  output logic       joy_strobe,
  output logic       joy_clock,
  output logic [7:0] buttons,
  output logic       present,
  output logic       valid
);

  localparam int C_poll_period = C_clk_hz / C_poll_hz;
  localparam int C_poll_w      = (C_poll_period > 1) ? $clog2(C_poll_period) : 1;
  localparam int C_phase_max   = (C_strobe_cycles > C_half_cycles) ? C_strobe_cycles : C_half_cycles;
  localparam int C_phase_w     = (C_phase_max > 1) ? $clog2(C_phase_max) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_SETTLE,
    S_HI,
    S_LO,
    S_DONE
  } t_state;

  t_state                 r_state;
  logic [C_poll_w-1:0]    r_poll;
  logic [C_phase_w-1:0]   r_phase;
  logic [3:0]             r_k;
  logic [7:0]             r_shift;
  logic                   r_pres;
  logic                   r_pending;
  logic [1:0]             r_sync;
  logic                   r_strobe;
  logic                   r_jclk;
  logic [7:0]             r_buttons;
  logic                   r_present;
  logic                   r_valid;
`ifdef JOY_DEBOUNCE_EN
  logic [7:0]             r_last;
`endif

  logic w_tick;
  logic w_bit;
  logic w_strobe_last;
  logic w_half_last;

  assign w_tick        = (r_poll == C_poll_w'(C_poll_period - 1));
  // Pad drives low for a pressed button, so the sampled bit is inverted.
  assign w_bit         = ~r_sync[1];
  assign w_strobe_last = (r_phase == C_phase_w'(C_strobe_cycles - 1));
  assign w_half_last   = (r_phase == C_phase_w'(C_half_cycles - 1));

  assign joy_strobe = r_strobe;
  assign joy_clock  = r_jclk;
  assign buttons    = r_buttons;
  assign present    = r_present;
  assign valid      = r_valid;

  always_ff @(posedge clock) begin
    if (R_reset) begin
      r_poll <= '0;
      r_sync <= 2'b11;
    end else begin
      r_poll <= w_tick ? '0 : r_poll + 1'b1;
      r_sync <= {r_sync[0], joy_data};
    end
  end

  always_ff @(posedge clock) begin
    if (R_reset) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_k       <= 4'd0;
      r_shift   <= 8'h00;
      r_pres    <= 1'b0;
      r_pending <= 1'b0;
      r_strobe  <= 1'b0;
      r_jclk    <= 1'b0;
      r_buttons <= 8'h00;
      r_present <= 1'b0;
      r_valid   <= 1'b0;
`ifdef JOY_DEBOUNCE_EN
      r_last    <= 8'h00;
`endif
    end else begin
      r_valid <= 1'b0;
      // A tick arriving mid-frame is remembered once; extra ticks are dropped.
      if (w_tick && (r_state != S_IDLE))
        r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_tick || r_pending) begin
            r_state   <= S_STROBE;
            r_pending <= 1'b0;
            r_phase   <= '0;
            r_strobe  <= 1'b1;
          end
        end
        S_STROBE: begin
          if (w_strobe_last) begin
            r_state  <= S_SETTLE;
            r_phase  <= '0;
            r_strobe <= 1'b0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_SETTLE: begin
          if (w_half_last) begin
            r_shift[0] <= w_bit;
            r_k        <= 4'd1;
            r_state    <= S_HI;
            r_phase    <= '0;
            r_jclk     <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_HI: begin
          if (w_half_last) begin
            r_state <= S_LO;
            r_phase <= '0;
            r_jclk  <= 1'b0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_LO: begin
          if (w_half_last) begin
            r_phase <= '0;
            if (r_k == 4'd8) begin
              r_pres  <= w_bit;
              r_state <= S_DONE;
            end else begin
              r_shift[r_k[2:0]] <= w_bit;
              r_k               <= r_k + 4'd1;
              r_state           <= S_HI;
              r_jclk            <= 1'b1;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_valid   <= 1'b1;
          r_present <= r_pres;
`ifdef JOY_DEBOUNCE_EN
          r_last <= r_shift;
          if (!r_pres)
            r_buttons <= 8'h00;
          else if (r_shift == r_last)
            r_buttons <= r_shift;
`else
          r_buttons <= r_pres ? r_shift : 8'h00;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_joypad_poller.sv
// Directed bench for nes_joypad_poller with a 4021 pad model (grounded serial input).
module tb_nes_joypad_poller;

  logic       clock = 1'b0;
  logic       R_reset;
  logic       joy_data;
  logic       joy_strobe, joy_clock, present, valid;
  logic [7:0] buttons;

  logic       r2_reset;
  logic       joy_data2;
  logic       joy_strobe2, joy_clock2, present2, valid2;
  logic [7:0] buttons2;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  nes_joypad_poller #(
    .C_clk_hz(1000), .C_poll_hz(10), .C_strobe_cycles(8), .C_half_cycles(4)
  ) dut (
    .clock(clock), .R_reset(R_reset), .joy_data(joy_data),
    .joy_strobe(joy_strobe), .joy_clock(joy_clock),
    .buttons(buttons), .present(present), .valid(valid)
  );

  // P = 60: shorter than one 77-cycle frame, so ticks land mid-frame.
  nes_joypad_poller #(
    .C_clk_hz(600), .C_poll_hz(10), .C_strobe_cycles(8), .C_half_cycles(4)
  ) dut2 (
    .clock(clock), .R_reset(r2_reset), .joy_data(joy_data2),
    .joy_strobe(joy_strobe2), .joy_clock(joy_clock2),
    .buttons(buttons2), .present(present2), .valid(valid2)
  );

  // Pad: parallel load while strobe is high, shift on joy_clock rise, zeros shifted in.
  logic [7:0] pad_pressed = 8'h00;
  logic       pad_on = 1'b1;
  logic [7:0] pad_sr = 8'hFF;
  logic       pad_jc_prev = 1'b0;
  always @(posedge clock) begin
    if (joy_strobe)
      pad_sr <= ~pad_pressed;
    else if (joy_clock && !pad_jc_prev)
      pad_sr <= {1'b0, pad_sr[7:1]};
    pad_jc_prev <= joy_clock;
  end
  assign joy_data = pad_on ? pad_sr[0] : 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] pressed;
    logic       on;
    logic [7:0] exp_btn;
    logic [7:0] exp_btn_db;
    logic       exp_pres;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit ok;
    int c0, s, vj, last_v, nv, s_new;
    int bad_st, bad_jc, pulses;
    logic prev;
    int rises[$];
    logic [7:0] exp;

    vecs[0] = '{8'h09, 1'b1, 8'h09, 8'h09, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 8'h00, 1'b1};
    vecs[3] = '{8'h81, 1'b1, 8'h81, 8'h00, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 8'h81, 8'h81, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 8'h80, 8'h81, 1'b1};
    vecs[6] = '{8'h00, 1'b1, 8'h00, 8'h81, 1'b1};
    vecs[7] = '{8'h5A, 1'b1, 8'h5A, 8'h81, 1'b1};
    vecs[8] = '{8'h5A, 1'b1, 8'h5A, 8'h5A, 1'b1};
    vecs[9] = '{8'hA5, 1'b0, 8'h00, 8'h00, 1'b0};

    R_reset = 1'b1; r2_reset = 1'b1; joy_data2 = 1'b1;
    pad_on = 1'b1; pad_pressed = 8'h09;
    repeat (3) @(negedge clock);
    chk("reset_strobe", int'(joy_strobe), 0);
    chk("reset_jclk", int'(joy_clock), 0);
    chk("reset_buttons", int'(buttons), 0);
    chk("reset_present", int'(present), 0);
    chk("reset_valid", int'(valid), 0);

    // First frame: timing trace of strobe, shift clock and valid.
    R_reset = 1'b0;
    c0 = cyc;
    s = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (joy_strobe) begin s = cyc; break; end
    end
    chk("first_strobe_delay", s - c0, 100);
    bad_st = 0; bad_jc = 0; pulses = 0; vj = -1; prev = 1'b0;
    for (int j = 0; j < 80; j++) begin
      if (j > 0) @(negedge clock);
      if (joy_strobe !== (j < 8)) bad_st++;
      if (joy_clock !== (j >= 12 && j < 76 && ((j - 12) % 8) < 4)) bad_jc++;
      if (joy_clock && !prev) pulses++;
      prev = joy_clock;
      if (valid) vj = j;
    end
    chk("strobe_wave_errs", bad_st, 0);
    chk("jclk_wave_errs", bad_jc, 0);
    chk("jclk_pulses", pulses, 8);
    chk("valid_offset", vj, 77);
`ifdef JOY_DEBOUNCE_EN
    chk("frame1_buttons", int'(buttons), 8'h00);
`else
    chk("frame1_buttons", int'(buttons), 8'h09);
`endif
    chk("frame1_present", int'(present), 1);
    last_v = s + 77;

    foreach (vecs[i]) begin
      pad_pressed = vecs[i].pressed;
      pad_on = vecs[i].on;
      wait_valid(ok);
      chk($sformatf("vec%0d_valid_seen", i), int'(ok), 1);
`ifdef JOY_DEBOUNCE_EN
      exp = vecs[i].exp_btn_db;
`else
      exp = vecs[i].exp_btn;
`endif
      chk($sformatf("vec%0d_buttons", i), int'(buttons), int'(exp));
      chk($sformatf("vec%0d_present", i), int'(present), int'(vecs[i].exp_pres));
      chk($sformatf("vec%0d_valid_period", i), cyc - last_v, 100);
      last_v = cyc;
      @(negedge clock);
      chk($sformatf("vec%0d_valid_width", i), int'(valid), 0);
    end

    // Reset during HI of the 4th shift pulse.
    pad_on = 1'b1; pad_pressed = 8'h09;
    wait_valid(ok);
    wait_valid(ok);
    chk("pre_reset_buttons", int'(buttons), 8'h09);
    s = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (joy_strobe) begin s = cyc; break; end
    end
    chk("pre_reset_strobe_seen", int'(s >= 0), 1);
    repeat (37) @(negedge clock);
    chk("in_hi_pulse4", int'(joy_clock), 1);
    R_reset = 1'b1;
    @(negedge clock);
    chk("mid_reset_strobe", int'(joy_strobe), 0);
    chk("mid_reset_jclk", int'(joy_clock), 0);
    chk("mid_reset_buttons", int'(buttons), 0);
    chk("mid_reset_present", int'(present), 0);
    chk("mid_reset_valid", int'(valid), 0);
    R_reset = 1'b0;
    c0 = cyc;
    nv = 0; s_new = -1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (valid) nv++;
      if (joy_strobe && s_new < 0) s_new = cyc;
    end
    chk("post_reset_no_valid", nv, 0);
    chk("post_reset_strobe_delay", s_new - c0, 100);

    // Pending tick: P=60 against a 77-cycle frame.
    r2_reset = 1'b0;
    c0 = cyc;
    nv = 0; prev = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clock);
      if (valid2) nv++;
      if (joy_strobe2 && !prev) rises.push_back(cyc - c0);
      prev = joy_strobe2;
    end
    chk("pend_rise_count", rises.size(), 3);
    if (rises.size() == 3) begin
      chk("pend_rise0", rises[0], 60);
      chk("pend_rise1", rises[1], 138);
      chk("pend_rise2", rises[2], 216);
    end
    chk("pend_valid_count", nv, 2);
    chk("pend_present", int'(present2), 0);
    chk("pend_buttons", int'(buttons2), 0);
    chk("pend_jclk_idle_or_active", int'(joy_clock2 === 1'bx), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
